conv_window_feeder: RTL and testbench
=====================================

Name: conv_window_feeder

Overview:
- Drives the y_conv convolution interface from the initiator side.
- Fetches pixels from an image SRAM and assembles each stride-1 3x3 window.
- Pulses calc_enable per window, waits for calc_done, captures conv and hands it downstream with a valid/ready handshake.
- Sits between the image buffer and the output/magnitude stage; sweeps one full frame per start.

Parameters:
IMG_WIDTH, 9, image columns (>=3)
IMG_HEIGHT, 9, image rows (>=3)
ADDR_W, 7, SRAM address width (must cover IMG_WIDTH*IMG_HEIGHT)
TIMEOUT_CYC, 31, max WAIT cycles for calc_done before abort

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  begin frame sweep; sampled in IDLE only
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after last result accepted
error  out  1  sticky timeout flag; cleared on accepted start
mem_ren  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM address, row-major, (row*IMG_WIDTH + col)
mem_rdata  in  4  SRAM data, valid the cycle after mem_ren
calc_enable  out  1  one-cycle pulse to y_conv
pixels  out  [2:0][2:0][3:0]  window; pixels[i][j] = image[r+i][c+j]
calc_done  in  1  y_conv result valid (level)
conv  in  10  y_conv result
result_valid  out  1  result available downstream
result_data  out  10  captured conv
result_row  out  ADDR_W  window top-left row r
result_col  out  ADDR_W  window top-left column c
result_ready  in  1  downstream accept

Behaviour:
- Reset (async, n_rst=0): state IDLE, r=c=0, all outputs 0, pixels cleared. Reset mid-sweep abandons the frame; no frame_done.
- States: IDLE, FETCH, CAPTURE, CALC, WAIT, OUTPUT, DONE.
- IDLE: start=1 -> FETCH, r=c=0, error cleared. start in any other state ignored.
- FETCH: 9 cycles, mem_ren=1, index k=0..8 issues addr (r+k/3)*IMG_WIDTH + (c+k%3).
- Data for read in cycle n is stored into pixels[k/3][k%3] at end of cycle n+1.
- CAPTURE: 1 cycle, stores 9th datum; mem_ren=0.
- CALC: calc_enable=1 for exactly one cycle; pixels stable from CALC until the next FETCH write.
- WAIT: cycle immediately after CALC ignores calc_done (y_conv may still show the prior result).
  - From the second WAIT cycle, calc_done=1 -> latch conv into result_data, latch r,c -> OUTPUT.
  - No calc_done within TIMEOUT_CYC WAIT cycles -> error=1, -> IDLE, no frame_done.
- Latency: start sampled at edge 0 -> mem_ren cycles 1..9 -> calc_enable cycle 11.
- OUTPUT: result_valid=1; result_data/row/col held stable while result_ready=0.
  - Transfer on result_valid & result_ready.
  - After transfer: if c<IMG_WIDTH-3, c++ -> FETCH.
  - Else if r<IMG_HEIGHT-3, c=0, r++ -> FETCH.
  - Else -> DONE.
  - result_valid drops the cycle after transfer.
- DONE: frame_done=1 one cycle -> IDLE.
- Results per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2); 49 for 9x9, emitted row-major.
- Wrap: c wraps 0 only at IMG_WIDTH-3; addresses never exceed IMG_WIDTH*IMG_HEIGHT-1.
- conv passed through unmodified (10-bit, no sign handling here).
- calc_done high while not in WAIT is ignored.

Test Plan:
- SRAM model data=addr mod 16, start at edge 0 -> addrs 0,1,2,9,10,11,18,19,20 in cycles 1..9; calc_enable in cycle 11; pixels[2][2]=4'h4 (addr 20).
- y_conv model returns conv=10'd100+window index, calc_done 6 cycles after calc_enable, result_ready=1 -> 49 results; (row,col) from (0,0) to (6,6) row-major; result_data 100..148; frame_done one pulse after the 49th transfer.
- result_ready=0 for 5 cycles on the first result -> result_valid stays 1, result_data/row/col unchanged, no FETCH; accepted on ready=1; next window addrs 1,2,3,10,...
- y_conv model holds calc_done=1 continuously from the prior window -> result not accepted in the first WAIT cycle; captured conv is the new value.
- calc_done never asserted -> error=1 after 31 WAIT cycles, busy=0, no frame_done; next start clears error.
- n_rst pulsed low mid-FETCH of window (2,3) -> all outputs 0 immediately; start pulsed while busy has no effect; fresh start after reset sweeps from (0,0).

Source files
------------

// File: rtl/conv_window_feeder.sv
// Sweeps an image in stride-1 3x3 windows: fetches each window from SRAM, runs
// y_conv on it and hands every result downstream over a valid/ready handshake.
module conv_window_feeder #(
   parameter int unsigned IMG_WIDTH   = 9,
   parameter int unsigned IMG_HEIGHT  = 9,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned TIMEOUT_CYC = 31
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   error,
   output logic                   mem_ren,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic [3:0]             mem_rdata,
   output logic                   calc_enable,
   output logic [2:0][2:0][3:0]   pixels,
   input  logic                   calc_done,
   input  logic [9:0]             conv,
   output logic                   result_valid,
   output logic [9:0]             result_data,
   output logic [ADDR_W-1:0]      result_row,
   output logic [ADDR_W-1:0]      result_col,
   input  logic                   result_ready
);

   localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, CALC, WAIT, OUTPUT, DONE} state_t;

   state_t                 state, state_d;
   logic [ADDR_W-1:0]      r, r_d, c, c_d;
   logic [3:0]             k, k_d;
   logic [WCNT_W-1:0]      wcnt, wcnt_d;
   logic                   busy_d, frame_done_d, error_d, mem_ren_d, calc_enable_d, result_valid_d;
   logic [ADDR_W-1:0]      mem_addr_d, result_row_d, result_col_d;
   logic [9:0]             result_data_d;
   logic [2:0][2:0][3:0]   pixels_d;
   logic                   wen;
   logic [3:0]             widx;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] rr,
                                                 input logic [ADDR_W-1:0] cc,
                                                 input logic [3:0]        kk);
      int unsigned row_i, col_i;
      row_i = 32'(rr) + 32'(kk) / 32'd3;
      col_i = 32'(cc) + 32'(kk) % 32'd3;
      return ADDR_W'(row_i * IMG_WIDTH + col_i);
   endfunction

   // Next state and next values of every registered output.
   always_comb begin
      state_d        = state;
      r_d            = r;
      c_d            = c;
      k_d            = k;
      wcnt_d         = wcnt;
      frame_done_d   = 1'b0;
      error_d        = error;
      mem_ren_d      = 1'b0;
      mem_addr_d     = '0;
      calc_enable_d  = 1'b0;
      result_valid_d = result_valid;
      result_data_d  = result_data;
      result_row_d   = result_row;
      result_col_d   = result_col;
      pixels_d       = pixels;
      wen            = 1'b0;
      widx           = k - 4'd1;

      case (state)
         IDLE: begin
            if (start) begin
               state_d    = FETCH;
               r_d        = '0;
               c_d        = '0;
               k_d        = '0;
               error_d    = 1'b0;
               mem_ren_d  = 1'b1;
               mem_addr_d = addr_of('0, '0, 4'd0);
            end
         end
         FETCH: begin
            // Read data lags the strobe by one cycle, so write slot k-1.
            wen = (k != 4'd0);
            if (k == 4'd8) begin
               state_d = CAPTURE;
            end else begin
               k_d        = k + 4'd1;
               mem_ren_d  = 1'b1;
               mem_addr_d = addr_of(r, c, k + 4'd1);
            end
         end
         CAPTURE: begin
            wen           = 1'b1;
            widx          = 4'd8;
            state_d       = CALC;
            calc_enable_d = 1'b1;
         end
         CALC: begin
            state_d = WAIT;
            wcnt_d  = '0;
         end
         WAIT: begin
            // First WAIT cycle may still show the previous window's result.
            if (wcnt != '0 && calc_done) begin
               state_d        = OUTPUT;
               result_valid_d = 1'b1;
               result_data_d  = conv;
               result_row_d   = r;
               result_col_d   = c;
            end else if (wcnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else begin
               wcnt_d = wcnt + WCNT_W'(1);
            end
         end
         OUTPUT: begin
            if (result_ready) begin
               result_valid_d = 1'b0;
               k_d            = '0;
               if (c < ADDR_W'(IMG_WIDTH - 3)) begin
                  c_d = c + ADDR_W'(1);
               end else if (r < ADDR_W'(IMG_HEIGHT - 3)) begin
                  c_d = '0;
                  r_d = r + ADDR_W'(1);
               end
               if (c < ADDR_W'(IMG_WIDTH - 3) || r < ADDR_W'(IMG_HEIGHT - 3)) begin
                  state_d    = FETCH;
                  mem_ren_d  = 1'b1;
                  mem_addr_d = addr_of(r_d, c_d, 4'd0);
               end else begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (wen && widx == 4'(i * 3 + j)) begin
               pixels_d[2'(i)][2'(j)] = mem_rdata;
            end
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         r            <= '0;
         c            <= '0;
         k            <= '0;
         wcnt         <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         error        <= 1'b0;
         mem_ren      <= 1'b0;
         mem_addr     <= '0;
         calc_enable  <= 1'b0;
         pixels       <= '0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_row   <= '0;
         result_col   <= '0;
      end else begin
         state        <= state_d;
         r            <= r_d;
         c            <= c_d;
         k            <= k_d;
         wcnt         <= wcnt_d;
         busy         <= busy_d;
         frame_done   <= frame_done_d;
         error        <= error_d;
         mem_ren      <= mem_ren_d;
         mem_addr     <= mem_addr_d;
         calc_enable  <= calc_enable_d;
         pixels       <= pixels_d;
         result_valid <= result_valid_d;
         result_data  <= result_data_d;
         result_row   <= result_row_d;
         result_col   <= result_col_d;
      end
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: SRAM and y_conv models plus a result scoreboard
// derived from the window geometry of the image.
module tb_conv_window_feeder;

   localparam int W    = 9;
   localparam int H    = 9;
   localparam int AW   = 7;
   localparam int NWIN = (W - 2) * (H - 2);

   logic clk = 1'b0;
   logic n_rst, start, busy, frame_done, error, mem_ren, calc_enable;
   logic calc_done, result_valid, result_ready;
   logic [AW-1:0] mem_addr, result_row, result_col;
   logic [3:0] mem_rdata;
   logic [2:0][2:0][3:0] pixels;
   logic [9:0] conv, result_data;

   int total = 0;
   int bad   = 0;
   logic [3:0]  img [0:W*H-1];
   logic [23:0] exp_q [$];
   int mode;         // 0: normal y_conv, 1: calc_done held high, 2: never done
   bit seq_conv, rand_ready;
   int stall_left, nres, nfd, widx;

   always #5 clk = ~clk;

   conv_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .TIMEOUT_CYC(31)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .frame_done(frame_done),
      .error(error), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .calc_enable(calc_enable), .pixels(pixels), .calc_done(calc_done), .conv(conv),
      .result_valid(result_valid), .result_data(result_data), .result_row(result_row),
      .result_col(result_col), .result_ready(result_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // SRAM: data for a read strobed in one cycle appears in the next; garbage otherwise.
   initial begin : sram
      logic pend_ren;
      logic [AW-1:0] pend_addr;
      pend_ren = 1'b0; pend_addr = '0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!n_rst) pend_ren = 1'b0;
         else begin
            mem_rdata = pend_ren ? img[pend_addr] : 4'($urandom);
            pend_ren  = mem_ren;
            pend_addr = mem_addr;
            if (mem_ren) check("addr_range", 64'(mem_addr < AW'(W * H)), 64'd1);
         end
      end
   end

   // y_conv: checks the presented window, produces a result after a mode-dependent delay.
   initial begin : yconv
      int cnt, wr, wc;
      logic [9:0] pend;
      logic [2:0][2:0][3:0] ep;
      cnt = 0; pend = '0; calc_done = 1'b0; conv = '0; widx = 0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            cnt = 0; calc_done = 1'b0; conv = '0; widx = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin calc_done = 1'b1; conv = pend; end
            end
            if (calc_enable) begin
               wr = widx / (W - 2);
               wc = widx % (W - 2);
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     ep[i][j] = img[(wr + i) * W + wc + j];
               check("pixels", 64'(pixels), 64'(ep));
               pend = seq_conv ? 10'(100 + widx) : 10'($urandom);
               exp_q.push_back({pend, AW'(wr), AW'(wc)});
               widx++;
               if (mode != 1) calc_done = 1'b0;
               cnt = (mode == 0) ? 6 : (mode == 1) ? 2 : 0;
            end
         end
      end
   end

   // Downstream sink: drives ready, scores transfers, checks hold behaviour.
   initial begin : sink
      bit prev_valid, xfer_prev, xfer_now;
      logic [23:0] prev_vals, got, want;
      prev_valid = 0; xfer_prev = 0; prev_vals = '0; result_ready = 1'b0; nres = 0; nfd = 0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            prev_valid = 0; xfer_prev = 0; result_ready = 1'b0;
         end else begin
            got = {result_data, result_row, result_col};
            if (frame_done) begin
               check("fd_after_xfer", 64'(xfer_prev), 64'd1);
               nfd++;
            end
            if (xfer_prev) check("valid_drop", 64'(result_valid), 64'd0);
            if (prev_valid) begin
               check("valid_hold", 64'(result_valid), 64'd1);
               check("hold_stable", 64'(got), 64'(prev_vals));
               check("no_fetch_stall", 64'(mem_ren), 64'd0);
            end
            xfer_now = 0;
            if (stall_left > 0 && result_valid) begin
               result_ready = 1'b0;
               stall_left--;
            end else begin
               result_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (result_valid && result_ready) begin
               check("exp_avail", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  want = exp_q.pop_front();
                  check("result", 64'(got), 64'(want));
               end
               nres++;
               xfer_now = 1;
            end
            prev_valid = result_valid && !xfer_now;
            prev_vals  = got;
            xfer_prev  = xfer_now;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1);
   end

   task automatic prep(input int m, input bit sq, input bit rr, input int st, input bit seq_img);
      mode = m; seq_conv = sq; rand_ready = rr; stall_left = st;
      nres = 0; nfd = 0; widx = 0;
      exp_q.delete();
      for (int i = 0; i < W * H; i++) img[i] = seq_img ? 4'(i % 16) : 4'($urandom);
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (busy && cyc < max);
      check("idle_reached", 64'(busy), 64'd0);
   endtask

   task automatic frame_end_checks();
      check("n_results", 64'(nres), 64'(NWIN));
      check("n_frame_done", 64'(nfd), 64'd1);
      check("no_error", 64'(error), 64'd0);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic reset_checks();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_mem_ren", 64'(mem_ren), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_calc_enable", 64'(calc_enable), 64'd0);
      check("rst_pixels", 64'(pixels), 64'd0);
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_result_data", 64'(result_data), 64'd0);
      check("rst_result_rc", 64'({result_row, result_col}), 64'd0);
   endtask

   initial begin : main
      int cyc;
      int exp_addr [9];
      exp_addr = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
      n_rst = 1'b1; start = 1'b0;
      prep(0, 1, 0, 0, 1);
      #2 n_rst = 1'b0;
      repeat (2) @(negedge clk);
      reset_checks();
      @(negedge clk) n_rst = 1'b1;

      // Frame 1: addr-mod-16 image, sequential conv values, latency of the first window.
      do_start();
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         check("lat_busy", 64'(busy), 64'd1);
         check("lat_ren", 64'(mem_ren), 64'(n <= 9));
         if (n <= 9) check("lat_addr", 64'(mem_addr), 64'(exp_addr[n-1]));
         check("lat_cen", 64'(calc_enable), 64'(n == 11));
         if (n == 11) check("pix22", 64'(pixels[2][2]), 64'h4);
      end
      wait_idle(5000, cyc);
      frame_end_checks();

      // Frame 2: random image, first result stalled 5 cycles, random ready afterwards.
      prep(0, 0, 1, 5, 0);
      do_start();
      wait_idle(5000, cyc);
      frame_end_checks();

      // Frame 3: calc_done held high across windows.
      prep(1, 0, 1, 0, 0);
      do_start();
      wait_idle(5000, cyc);
      frame_end_checks();

      // Frame 4: y_conv never answers.
      prep(2, 0, 0, 0, 0);
      do_start();
      wait_idle(200, cyc);
      check("timeout_cycle", 64'(cyc), 64'd43);
      check("timeout_error", 64'(error), 64'd1);
      check("timeout_no_fd", 64'(nfd), 64'd0);
      check("timeout_no_res", 64'(nres), 64'd0);

      // Frame 5: start clears error, then reset during the fetch of window (2,3).
      prep(0, 0, 1, 0, 0);
      do_start();
      @(negedge clk);
      check("err_clear", 64'(error), 64'd0);
      cyc = 0;
      while (!(nres == 17 && mem_ren) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_w23", 64'(cyc < 3000), 64'd1);
      n_rst = 1'b0;
      #1 reset_checks();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk) n_rst = 1'b1;
      @(negedge clk);
      check("idle_after_rst", 64'(busy), 64'd0);
      check("abort_no_fd", 64'(nfd), 64'd0);

      // Frame 6: fresh sweep with a start pulse while busy.
      prep(0, 0, 1, 0, 0);
      do_start();
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_idle(5000, cyc);
      frame_end_checks();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
